pipe_cla_addsub: RTL and testbench

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

---
 rtl/pipe_cla_addsub.sv | 160 ++++++++++++++++
 tb/tb_pipe_cla_addsub.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: one 16-bit carry-lookahead group per stage, carry registered between stages.
// Latency NG cycles from input transfer to out_valid; throughput one result per cycle.
// Backpressure: per-stage valid/ready; a stage advances when empty or its successor advances, and bubbles collapse.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (a, b, cin, op)
//   op                : 0 = a + b + cin, 1 = a - b - cin (cin acts as borrow-in)
//   out_valid/out_ready : result handshake (sum, cout, ovf, zero)
module pipe_cla_addsub #(
  parameter int WIDTH = 64,        // multiple of 16, 16..256
  parameter int NG    = WIDTH / 16 // derived; do not override
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Two-level 16-bit CLA: four 4-bit lookahead groups, then lookahead across
  // the group generate/propagate terms. Returns {carry_out, sum[15:0]}.
  function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;
    g = x & y;
    p = x | y;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[4], x ^ y ^ c};
  endfunction

  // Stage k registers. a_q/b_q hold the operand groups not yet summed,
  // shifted down so the next stage always consumes bits [15:0]; s_q holds
  // the sum groups 0..k already produced; c_q is the carry out of group k.
  logic [NG-1:0]    valid_q;
  logic [NG-1:0]    c_q;
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] s_q [NG];
  logic             ovf_q, zero_q;

  logic [NG-1:0]    rdy, vin, nc;
  logic [WIDTH-1:0] na [NG];
  logic [WIDTH-1:0] nb [NG];
  logic [WIDTH-1:0] ns [NG];
  logic [WIDTH-1:0] b_eff;
  logic [16:0]      t;
  logic             am, bm, r, n_ovf, n_zero;

  // ready_k = !valid_k || ready_(k+1), unrolled from the output side so the
  // chain is a plain OR reduction with no combinational self-reference.
  always_comb begin
    rdy = '0;
    vin = '0;
    r   = out_ready;
    for (int k = NG - 1; k >= 0; k--) begin
      r      = r | ~valid_q[k];
      rdy[k] = r;
    end
    vin[0] = in_valid;
    for (int k = 1; k < NG; k++) vin[k] = valid_q[k-1];
  end

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      na[k] = '0;
      nb[k] = '0;
      ns[k] = '0;
    end
    nc    = '0;
    b_eff = b ^ {WIDTH{op}};
    t     = cla16(a[15:0], b_eff[15:0], cin ^ op);
    ns[0][15:0] = t[15:0];
    nc[0] = t[16];
    na[0] = a >> 16;
    nb[0] = b_eff >> 16;
    // Operand MSBs of the group handled by the last stage, for overflow.
    am = a[15];
    bm = b_eff[15];
    for (int k = 1; k < NG; k++) begin
      t     = cla16(a_q[k-1][15:0], b_q[k-1][15:0], c_q[k-1]);
      ns[k] = s_q[k-1];
      ns[k][16*k +: 16] = t[15:0];
      nc[k] = t[16];
      na[k] = a_q[k-1] >> 16;
      nb[k] = b_q[k-1] >> 16;
      am    = a_q[k-1][15];
      bm    = b_q[k-1][15];
    end
    n_ovf  = (am == bm) && (ns[NG-1][WIDTH-1] != am);
    n_zero = (ns[NG-1] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NG; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= vin[k];
          // Data only moves with a valid item; a bubble leaves old data in
          // place, which is never observed because valid is low.
          if (vin[k]) begin
            a_q[k] <= na[k];
            b_q[k] <= nb[k];
            s_q[k] <= ns[k];
            c_q[k] <= nc[k];
          end
        end
      end
      if (rdy[NG-1] && vin[NG-1]) begin
        ovf_q  <= n_ovf;
        zero_q <= n_zero;
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[NG-1];
  assign sum       = s_q[NG-1];
  assign cout      = c_q[NG-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Testbench for pipe_cla_addsub: directed vectors, handshake corner cases and
// randomized streams on 16-, 64- and 128-bit builds against an arithmetic model.
module tb_pipe_cla_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv64, ir64, ov64, or64, cin64, op64, co64, of64, z64;
  logic [63:0] a64, b64, s64;
  logic        iv16, ir16, ov16, or16, cin16, op16, co16, of16, z16;
  logic [15:0] a16, b16, s16;
  logic        iv128, ir128, ov128, or128, cin128, op128, co128, of128, z128;
  logic [127:0] a128, b128, s128;

  pipe_cla_addsub #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .cin(cin64), .op(op64), .out_valid(ov64), .out_ready(or64), .sum(s64),
    .cout(co64), .ovf(of64), .zero(z64));
  pipe_cla_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .op(op16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16), .zero(z16));
  pipe_cla_addsub #(.WIDTH(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .a(a128), .b(b128),
    .cin(cin128), .op(op128), .out_valid(ov128), .out_ready(or128), .sum(s128),
    .cout(co128), .ovf(of128), .zero(z128));

  typedef struct {
    logic [127:0] s;
    logic         co, ov, z;
  } res_t;

  typedef struct {
    logic [63:0] a, b;
    logic        cin, op;
    logic [63:0] s;
    logic        co, ov, z;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q64[$], q16[$], q128[$];
  vec_t vt[12];

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] pack_out(input logic v, input logic [127:0] s,
                                            input logic co, input logic ov, input logic z);
    return {v, z, ov, co, s};
  endfunction

  function automatic logic [131:0] pack_res(input res_t e);
    return {1'b1, e.z, e.ov, e.co, e.s};
  endfunction

  // Reference: plain wide arithmetic; overflow from the true signed sum.
  function automatic res_t model(input int w, input logic [127:0] a, input logic [127:0] b,
                                 input logic cin, input logic op);
    res_t r;
    logic [127:0] mask, am, be;
    logic [128:0] full;
    logic c;
    logic signed [131:0] sa, sb, tot, lim;
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    am   = a & mask;
    be   = op ? (~b & mask) : (b & mask);
    c    = cin ^ op;
    full = {1'b0, am} + {1'b0, be} + {128'd0, c};
    r.s  = full[127:0] & mask;
    r.co = full[w];
    sa = $signed({4'b0, am});
    if (am[w-1]) sa = sa - (132'sd1 <<< w);
    sb = $signed({4'b0, be});
    if (be[w-1]) sb = sb - (132'sd1 <<< w);
    tot  = sa + sb + $signed({131'd0, c});
    lim  = 132'sd1 <<< (w - 1);
    r.ov = (tot >= lim) || (tot < -lim);
    r.z  = (r.s == 128'd0);
    return r;
  endfunction

  function automatic logic [127:0] gen(input logic [127:0] o);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: r = {128{1'b1}};
      1: r = '0;
      2: r = ~o;
      3: r = o;
      default: ;
    endcase
    return r;
  endfunction

  task automatic pop64(input string name);
    res_t e;
    check({name, "_present"}, {131'd0, q64.size() != 0}, 132'd1);
    if (q64.size() != 0) begin
      e = q64.pop_front();
      check(name, pack_out(ov64, {64'd0, s64}, co64, of64, z64), pack_res(e));
    end
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    int   g;
    logic early;
    @(posedge clk); #1;
    a64 = v.a; b64 = v.b; cin64 = v.cin; op64 = v.op; iv64 = 1'b1; or64 = 1'b1;
    g = 0;
    @(negedge clk);
    while (!ir64 && g < 20) begin @(negedge clk); g++; end
    check({name, "_accept"}, {131'd0, ir64}, 132'd1);
    @(posedge clk); #1;
    // Scramble idle operands: they must be ignored.
    iv64 = 1'b0; a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
    cin64 = 1'($urandom_range(0, 1)); op64 = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    early = ov64;
    @(negedge clk);
    check({name, "_latency"}, {130'd0, early, ov64}, 132'd1);
    check(name, pack_out(ov64, {64'd0, s64}, co64, of64, z64),
          pack_out(1'b1, {64'd0, v.s}, v.co, v.ov, v.z));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, nout, acc, g, stale;
    logic [131:0] held, held64;
    logic hold64;
    logic [127:0] ta, tb2;
    res_t e;
    localparam int N = 600;

    vt[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{64'h5, 64'h3, 1'b1, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[10] = '{64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vt[11] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};

    iv64 = 0; a64 = '0; b64 = '0; cin64 = 0; op64 = 0; or64 = 1;
    iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; op16 = 0; or16 = 1;
    iv128 = 0; a128 = '0; b128 = '0; cin128 = 0; op128 = 0; or128 = 1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out64", pack_out(ov64, {64'd0, s64}, co64, of64, z64), 132'd0);
    check("reset_out16", pack_out(ov16, {112'd0, s16}, co16, of16, z16), 132'd0);
    check("reset_out128", pack_out(ov128, s128, co128, of128, z128), 132'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {129'd0, ir64, ir16, ir128}, 132'd7);

    // Directed vectors
    for (int i = 0; i < 12; i++) apply_vec($sformatf("vec%0d", i), vt[i]);

    // Back-to-back 8 transfers with out_ready held high
    first = -1; nout = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 8) begin
        iv64 = 1; a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
        cin64 = 1'($urandom_range(0, 1)); op64 = 1'($urandom_range(0, 1));
      end else iv64 = 0;
      @(negedge clk);
      if (iv64 && ir64) begin
        if (first < 0) first = cyc;
        q64.push_back(model(64, {64'd0, a64}, {64'd0, b64}, cin64, op64));
      end
      if (ov64) begin
        check($sformatf("b2b_cycle%0d", nout), 132'(cyc), 132'(first + 4 + nout));
        pop64($sformatf("b2b_res%0d", nout));
        nout++;
      end
    end
    check("b2b_count", 132'(nout), 132'd8);

    // Stall: out_ready low for 6 cycles while input keeps offering
    acc = 0; held = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      or64 = 0; iv64 = 1; a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
      cin64 = 1'($urandom_range(0, 1)); op64 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (iv64 && ir64) begin
        acc++;
        q64.push_back(model(64, {64'd0, a64}, {64'd0, b64}, cin64, op64));
      end
      if (cyc == 4) held = pack_out(ov64, {64'd0, s64}, co64, of64, z64);
      if (cyc == 5) check("stall_hold", pack_out(ov64, {64'd0, s64}, co64, of64, z64), held);
    end
    check("stall_accepted", 132'(acc), 132'd4);
    check("stall_in_ready_low", {131'd0, ir64}, 132'd0);
    @(posedge clk); #1;
    iv64 = 0; or64 = 1;
    nout = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (ov64 && or64) begin pop64($sformatf("stall_drain%0d", nout)); nout++; end
    end
    check("stall_drain_count", 132'(nout), 132'd4);

    // Asynchronous reset with results in flight
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      iv64 = 1; a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
      cin64 = 1'($urandom_range(0, 1)); op64 = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    iv64 = 0;
    g = 0;
    @(negedge clk);
    while (!ov64 && g < 10) begin @(negedge clk); g++; end
    check("rst_inflight_seen", {131'd0, ov64}, 132'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_clear", pack_out(ov64, {64'd0, s64}, co64, of64, z64), 132'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (ov64) stale++;
    end
    check("rst_no_stale", 132'(stale), 132'd0);
    check("rst_ready", {131'd0, ir64}, 132'd1);
    apply_vec("post_rst", '{64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1'b0});

    // Randomized streams on all three builds
    q64.delete(); q16.delete(); q128.delete();
    hold64 = 0; held64 = '0;
    for (int cyc = 0; cyc < N + 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc < N) begin
        iv64 = ($urandom_range(0, 3) != 0); or64 = ($urandom_range(0, 3) != 0);
        ta = gen('0); tb2 = gen(ta); a64 = ta[63:0]; b64 = tb2[63:0];
        cin64 = 1'($urandom_range(0, 1)); op64 = 1'($urandom_range(0, 1));
        iv16 = ($urandom_range(0, 3) != 0); or16 = ($urandom_range(0, 3) != 0);
        ta = gen('0); tb2 = gen(ta); a16 = ta[15:0]; b16 = tb2[15:0];
        cin16 = 1'($urandom_range(0, 1)); op16 = 1'($urandom_range(0, 1));
        iv128 = ($urandom_range(0, 3) != 0); or128 = ($urandom_range(0, 3) != 0);
        ta = gen('0); tb2 = gen(ta); a128 = ta; b128 = tb2;
        cin128 = 1'($urandom_range(0, 1)); op128 = 1'($urandom_range(0, 1));
      end else begin
        iv64 = 0; iv16 = 0; iv128 = 0;
        or64 = 1; or16 = 1; or128 = 1;
      end
      @(negedge clk);
      if (hold64) check("r64_hold", pack_out(ov64, {64'd0, s64}, co64, of64, z64), held64);
      hold64 = ov64 && !or64;
      held64 = pack_out(ov64, {64'd0, s64}, co64, of64, z64);

      if (iv64 && ir64) q64.push_back(model(64, {64'd0, a64}, {64'd0, b64}, cin64, op64));
      if (ov64 && or64) pop64("r64");

      if (iv16 && ir16) q16.push_back(model(16, {112'd0, a16}, {112'd0, b16}, cin16, op16));
      if (ov16 && or16) begin
        check("r16_present", {131'd0, q16.size() != 0}, 132'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          check("r16", pack_out(ov16, {112'd0, s16}, co16, of16, z16), pack_res(e));
        end
      end

      if (iv128 && ir128) q128.push_back(model(128, a128, b128, cin128, op128));
      if (ov128 && or128) begin
        check("r128_present", {131'd0, q128.size() != 0}, 132'd1);
        if (q128.size() != 0) begin
          e = q128.pop_front();
          check("r128", pack_out(ov128, s128, co128, of128, z128), pack_res(e));
        end
      end
    end
    check("r64_drained", 132'(q64.size()), 132'd0);
    check("r16_drained", 132'(q16.size()), 132'd0);
    check("r128_drained", 132'(q128.size()), 132'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
